ext_bus_master: RTL and testbench

EXT_BUS_MASTER -- requirements
Module: ext_bus_master

---
 rtl/ext_bus_pkg.sv | 26 ++
 rtl/ext_bus_master.sv | 172 +++++++++++++++++
 tb/tb_ext_bus_master.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ext_bus_pkg.sv
// Shared types and limits for the multiplexed external bus master.
package ext_bus_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 16;
  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;

  typedef enum logic [2:0] {
    IDLE,
    AH_STB,
    AH_HLD,
    AL_STB,
    AL_HLD,
    DATA,
    RECOV
  } state_t;

  // Down-counter reload value; out-of-range wait lengths are pinned to the legal window.
  function automatic logic [3:0] wait_load(input int cycles);
    int c;
    c = (cycles < WAIT_MIN) ? WAIT_MIN : ((cycles > WAIT_MAX) ? WAIT_MAX : cycles);
    return 4'(c - 1);
  endfunction

endpackage

// File: rtl/ext_bus_master.sv
// Multiplexed 16-bit external bus master: two latched address halves, then a data phase.
// Optional upper-address cache enabled by defining EXT_BUS_HI_CACHE_EN.
module ext_bus_master
  import ext_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_dir,
  output logic              le_lo,
  output logic              le_hi,
  output logic              OEb,
  output logic              WEb_lo,
  output logic              WEb_hi
);

  localparam logic [3:0] CNT_LOAD = wait_load(WAIT_CYCLES);

  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic [1:0]        r_be, w_be;
  logic              r_we, w_we;
  logic [3:0]        r_cnt;
  logic              w_accept, w_hit;

  logic              r_req_ready, r_rsp_valid, r_bus_dir, r_le_lo, r_le_hi;
  logic              r_oeb, r_web_lo, r_web_hi;
  logic [DATA_W-1:0] r_rsp_rdata, r_bus_out;
  logic              w_req_ready, w_rsp_valid, w_bus_dir, w_le_lo, w_le_hi;
  logic              w_oeb, w_web_lo, w_web_hi;
  logic [DATA_W-1:0] w_bus_out;

  assign w_accept = req_valid & r_req_ready;
  assign w_addr   = w_accept ? req_addr  : r_addr;
  assign w_wdata  = w_accept ? req_wdata : r_wdata;
  assign w_be     = w_accept ? req_be    : r_be;
  assign w_we     = w_accept ? req_we    : r_we;

`ifdef EXT_BUS_HI_CACHE_EN
  logic [15:0] r_hi_tag;
  logic        r_hi_valid;

  assign w_hit = r_hi_valid && (req_addr[31:16] == r_hi_tag);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_hi_tag   <= '0;
      r_hi_valid <= 1'b0;
    end else if (r_state == AH_HLD) begin
      r_hi_tag   <= r_addr[31:16];
      r_hi_valid <= 1'b1;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = w_hit ? AL_STB : AH_STB;
      AH_STB:  w_next = AH_HLD;
      AH_HLD:  w_next = AL_STB;
      AL_STB:  w_next = AL_HLD;
      AL_HLD:  w_next = DATA;
      DATA:    if (r_cnt == 4'd0) w_next = RECOV;
      RECOV:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_bus_out   = r_bus_out;
    w_bus_dir   = 1'b1;
    w_le_lo     = 1'b0;
    w_le_hi     = 1'b0;
    w_oeb       = 1'b1;
    w_web_lo    = 1'b1;
    w_web_hi    = 1'b1;
    unique case (w_next)
      IDLE:   w_req_ready = 1'b1;
      AH_STB: begin w_bus_out = w_addr[31:16]; w_bus_dir = 1'b0; w_le_hi = 1'b1; end
      AH_HLD: begin w_bus_out = w_addr[31:16]; w_bus_dir = 1'b0; end
      AL_STB: begin w_bus_out = w_addr[15:0];  w_bus_dir = 1'b0; w_le_lo = 1'b1; end
      AL_HLD: begin w_bus_out = w_addr[15:0];  w_bus_dir = 1'b0; end
      DATA: begin
        if (w_we) begin
          w_bus_dir = 1'b0;
          w_bus_out = w_wdata;
          w_web_lo  = ~w_be[0];
          w_web_hi  = ~w_be[1];
        end else begin
          w_oeb = 1'b0;
        end
      end
      RECOV:   w_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_bus_out   <= '0;
      r_bus_dir   <= 1'b1;
      r_le_lo     <= 1'b0;
      r_le_hi     <= 1'b0;
      r_oeb       <= 1'b1;
      r_web_lo    <= 1'b1;
      r_web_hi    <= 1'b1;
    end else begin
      r_state     <= w_next;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_be        <= w_be;
      r_we        <= w_we;
      r_req_ready <= w_req_ready;
      r_rsp_valid <= w_rsp_valid;
      r_bus_out   <= w_bus_out;
      r_bus_dir   <= w_bus_dir;
      r_le_lo     <= w_le_lo;
      r_le_hi     <= w_le_hi;
      r_oeb       <= w_oeb;
      r_web_lo    <= w_web_lo;
      r_web_hi    <= w_web_hi;
      if (w_next == DATA && r_state != DATA) begin
        r_cnt <= CNT_LOAD;
      end else if (r_state == DATA && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Read data is taken on the edge closing the final data cycle.
      if (r_state == DATA && r_cnt == 4'd0) begin
        r_rsp_rdata <= r_we ? '0 : bus_in;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign bus_out   = r_bus_out;
  assign bus_dir   = r_bus_dir;
  assign le_lo     = r_le_lo;
  assign le_hi     = r_le_hi;
  assign OEb       = r_oeb;
  assign WEb_lo    = r_web_lo;
  assign WEb_hi    = r_web_hi;

endmodule

// File: tb/tb_ext_bus_master.sv
// Directed bench for ext_bus_master: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=3.
// Cache expectations follow EXT_BUS_HI_CACHE_EN.
module tb_ext_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic [31:0] reqAddr;
  logic        reqWe;
  logic [1:0]  reqBe;
  logic [15:0] reqWdata;
  logic [15:0] busIn;
  int          sel;

  logic        readyA, rspValidA, dirA, leLoA, leHiA, oebA, webLoA, webHiA;
  logic [15:0] rdataA, busOutA;
  logic        readyB, rspValidB, dirB, leLoB, leHiB, oebB, webLoB, webHiB;
  logic [15:0] rdataB, busOutB;

  logic        ready, rspValid, dir, leLo, leHi, oeb, webLo, webHi;
  logic [15:0] rdata, busOut;

  int nChecks = 0;
  int nPass   = 0;

  int          nLeHi, nLeLo, nWebLo, nWebHi, nOe, nRsp, rspEdge;
  logic [15:0] hiBus, loBus, wrBus, rspData;
  logic        oeDirOk;

  always #5 clk = ~clk;

  ext_bus_master #(.WAIT_CYCLES(1)) dutA (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(reqValid && sel == 0), .req_ready(readyA),
    .req_addr(reqAddr), .req_we(reqWe), .req_be(reqBe), .req_wdata(reqWdata),
    .rsp_valid(rspValidA), .rsp_rdata(rdataA),
    .bus_in(busIn), .bus_out(busOutA), .bus_dir(dirA),
    .le_lo(leLoA), .le_hi(leHiA), .OEb(oebA), .WEb_lo(webLoA), .WEb_hi(webHiA)
  );

  ext_bus_master #(.WAIT_CYCLES(3)) dutB (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(reqValid && sel == 1), .req_ready(readyB),
    .req_addr(reqAddr), .req_we(reqWe), .req_be(reqBe), .req_wdata(reqWdata),
    .rsp_valid(rspValidB), .rsp_rdata(rdataB),
    .bus_in(busIn), .bus_out(busOutB), .bus_dir(dirB),
    .le_lo(leLoB), .le_hi(leHiB), .OEb(oebB), .WEb_lo(webLoB), .WEb_hi(webHiB)
  );

  assign ready    = (sel == 1) ? readyB    : readyA;
  assign rspValid = (sel == 1) ? rspValidB : rspValidA;
  assign rdata    = (sel == 1) ? rdataB    : rdataA;
  assign busOut   = (sel == 1) ? busOutB   : busOutA;
  assign dir      = (sel == 1) ? dirB      : dirA;
  assign leLo     = (sel == 1) ? leLoB     : leLoA;
  assign leHi     = (sel == 1) ? leHiB     : leHiA;
  assign oeb      = (sel == 1) ? oebB      : oebA;
  assign webLo    = (sel == 1) ? webLoB    : webLoA;
  assign webHi    = (sel == 1) ? webHiB    : webHiA;

  // Strobe exclusivity and latch-enable direction, watched on both instances throughout.
  assert property (@(posedge clk) disable iff (rst)
    !((leLoA | leHiA) & (~oebA | ~webLoA | ~webHiA)) && !(leLoA & leHiA) && !(~oebA & (~webLoA | ~webHiA)))
    else begin nChecks++; $display("[TB] FAIL overlapA: le_lo=%b le_hi=%b OEb=%b WEb=%b%b required no overlap", leLoA, leHiA, oebA, webHiA, webLoA); end
  assert property (@(posedge clk) disable iff (rst)
    !((leLoB | leHiB) & (~oebB | ~webLoB | ~webHiB)) && !(leLoB & leHiB) && !(~oebB & (~webLoB | ~webHiB)))
    else begin nChecks++; $display("[TB] FAIL overlapB: le_lo=%b le_hi=%b OEb=%b WEb=%b%b required no overlap", leLoB, leHiB, oebB, webHiB, webLoB); end
  assert property (@(posedge clk) disable iff (rst) ($rose(leLoA) || $rose(leHiA)) |-> !dirA)
    else begin nChecks++; $display("[TB] FAIL leDirA: bus_dir=%b required 0", dirA); end
  assert property (@(posedge clk) disable iff (rst) ($rose(leLoB) || $rose(leHiB)) |-> !dirB)
    else begin nChecks++; $display("[TB] FAIL leDirB: bus_dir=%b required 0", dirB); end

  // Runs one transaction on the selected instance and records what the pins did.
  // Cycle n is the cycle after the n-th edge, counting the accept edge as 1.
  task automatic runTxn(input logic [31:0] addr, input logic we, input logic [1:0] be,
                        input logic [15:0] wdata, input int lastDataN);
    int n;
    nLeHi = 0; nLeLo = 0; nWebLo = 0; nWebHi = 0; nOe = 0; nRsp = 0; rspEdge = 0;
    hiBus = 'x; loBus = 'x; wrBus = 'x; rspData = 'x; oeDirOk = 1'b1;
    busIn = 16'h0BAD;
    @(negedge clk);
    nChecks++;
    if (ready !== 1'b1) $display("[TB] FAIL readyBeforeAccept: got %b expected 1", ready);
    else nPass++;
    reqAddr = addr; reqWe = we; reqBe = be; reqWdata = wdata; reqValid = 1'b1;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    for (n = 1; n <= 20; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      busIn = (n == lastDataN) ? 16'hBEEF : 16'h0BAD;
      if (leHi)   begin nLeHi++;  hiBus = busOut; end
      if (leLo)   begin nLeLo++;  loBus = busOut; end
      if (!webLo) begin nWebLo++; wrBus = busOut; end
      if (!webHi) nWebHi++;
      if (!oeb)   begin nOe++; if (!dir) oeDirOk = 1'b0; end
      if (rspValid) begin nRsp++; rspEdge = n; rspData = rdata; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; reqValid = 1'b0; reqAddr = '0; reqWe = 1'b0; reqBe = '0; reqWdata = '0; busIn = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      nChecks++; if (ready !== 1'b0)      $display("[TB] FAIL rstReady%0d: got %b expected 0", s, ready); else nPass++;
      nChecks++; if (rspValid !== 1'b0)   $display("[TB] FAIL rstRspValid%0d: got %b expected 0", s, rspValid); else nPass++;
      nChecks++; if (rdata !== 16'h0)     $display("[TB] FAIL rstRdata%0d: got %h expected 0000", s, rdata); else nPass++;
      nChecks++; if (busOut !== 16'h0)    $display("[TB] FAIL rstBusOut%0d: got %h expected 0000", s, busOut); else nPass++;
      nChecks++; if ({dir, oeb, webLo, webHi, leLo, leHi} !== 6'b111100)
        $display("[TB] FAIL rstPins%0d: got %b expected 111100", s, {dir, oeb, webLo, webHi, leLo, leHi}); else nPass++;
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    nChecks++; if (ready !== 1'b0) $display("[TB] FAIL readyBeforeEdge: got %b expected 0", ready); else nPass++;
    @(posedge clk);
    #1;
    nChecks++; if (ready !== 1'b1) $display("[TB] FAIL readyAfterRelease: got %b expected 1", ready); else nPass++;
  endtask

  task automatic test_write();
    sel = 0;
    runTxn(32'h0020_0006, 1'b1, 2'b01, 16'h0041, 0);
    nChecks++; if (nLeHi !== 1)         $display("[TB] FAIL wrLeHiCount: got %0d expected 1", nLeHi); else nPass++;
    nChecks++; if (hiBus !== 16'h0020)  $display("[TB] FAIL wrHiBus: got %h expected 0020", hiBus); else nPass++;
    nChecks++; if (nLeLo !== 1)         $display("[TB] FAIL wrLeLoCount: got %0d expected 1", nLeLo); else nPass++;
    nChecks++; if (loBus !== 16'h0006)  $display("[TB] FAIL wrLoBus: got %h expected 0006", loBus); else nPass++;
    nChecks++; if (nWebLo !== 1)        $display("[TB] FAIL wrWebLoCount: got %0d expected 1", nWebLo); else nPass++;
    nChecks++; if (wrBus !== 16'h0041)  $display("[TB] FAIL wrDataBus: got %h expected 0041", wrBus); else nPass++;
    nChecks++; if (nWebHi !== 0)        $display("[TB] FAIL wrWebHiCount: got %0d expected 0", nWebHi); else nPass++;
    nChecks++; if (nOe !== 0)           $display("[TB] FAIL wrOeCount: got %0d expected 0", nOe); else nPass++;
    nChecks++; if (nRsp !== 1)          $display("[TB] FAIL wrRspCount: got %0d expected 1", nRsp); else nPass++;
    nChecks++; if (rspEdge !== 6)       $display("[TB] FAIL wrLatency: got %0d expected 6", rspEdge); else nPass++;
    nChecks++; if (rspData !== 16'h0)   $display("[TB] FAIL wrRdata: got %h expected 0000", rspData); else nPass++;
  endtask

  task automatic test_read();
    sel = 1;
    runTxn(32'h0000_0010, 1'b0, 2'b11, 16'hFFFF, 7);
    nChecks++; if (nOe !== 3)            $display("[TB] FAIL rdOeCount: got %0d expected 3", nOe); else nPass++;
    nChecks++; if (oeDirOk !== 1'b1)     $display("[TB] FAIL rdDirDuringOe: got %b expected 1", oeDirOk); else nPass++;
    nChecks++; if (nWebLo + nWebHi !== 0) $display("[TB] FAIL rdWebCount: got %0d expected 0", nWebLo + nWebHi); else nPass++;
    nChecks++; if (loBus !== 16'h0010)   $display("[TB] FAIL rdLoBus: got %h expected 0010", loBus); else nPass++;
    nChecks++; if (rspData !== 16'hBEEF) $display("[TB] FAIL rdRdata: got %h expected beef", rspData); else nPass++;
    nChecks++; if (rspEdge !== 8)        $display("[TB] FAIL rdLatency: got %0d expected 8", rspEdge); else nPass++;
    nChecks++; if (nRsp !== 1)           $display("[TB] FAIL rdRspCount: got %0d expected 1", nRsp); else nPass++;
  endtask

  task automatic test_be_zero();
    sel = 0;
    runTxn(32'h0030_0008, 1'b1, 2'b00, 16'h5A5A, 0);
    nChecks++; if (nWebLo !== 0)  $display("[TB] FAIL be0WebLo: got %0d expected 0", nWebLo); else nPass++;
    nChecks++; if (nWebHi !== 0)  $display("[TB] FAIL be0WebHi: got %0d expected 0", nWebHi); else nPass++;
    nChecks++; if (nRsp !== 1)    $display("[TB] FAIL be0RspCount: got %0d expected 1", nRsp); else nPass++;
    nChecks++; if (rspEdge !== 6) $display("[TB] FAIL be0Latency: got %0d expected 6", rspEdge); else nPass++;
  endtask

  task automatic test_back_to_back();
    int expLeHi, expEdge, lastN;
    sel = 0;
    runTxn(32'h0000_1000, 1'b0, 2'b11, 16'h0000, 5);
    nChecks++; if (nLeHi !== 1)          $display("[TB] FAIL b2bFirstLeHi: got %0d expected 1", nLeHi); else nPass++;
    nChecks++; if (rspEdge !== 6)        $display("[TB] FAIL b2bFirstLatency: got %0d expected 6", rspEdge); else nPass++;
    nChecks++; if (rspData !== 16'hBEEF) $display("[TB] FAIL b2bFirstRdata: got %h expected beef", rspData); else nPass++;
`ifdef EXT_BUS_HI_CACHE_EN
    expLeHi = 0; expEdge = 4; lastN = 3;
`else
    expLeHi = 1; expEdge = 6; lastN = 5;
`endif
    runTxn(32'h0000_1002, 1'b0, 2'b11, 16'h0000, lastN);
    nChecks++; if (nLeHi !== expLeHi)    $display("[TB] FAIL b2bSecondLeHi: got %0d expected %0d", nLeHi, expLeHi); else nPass++;
    nChecks++; if (nLeLo !== 1)          $display("[TB] FAIL b2bSecondLeLo: got %0d expected 1", nLeLo); else nPass++;
    nChecks++; if (loBus !== 16'h1002)   $display("[TB] FAIL b2bSecondLoBus: got %h expected 1002", loBus); else nPass++;
    nChecks++; if (rspEdge !== expEdge)  $display("[TB] FAIL b2bSecondLatency: got %0d expected %0d", rspEdge, expEdge); else nPass++;
    nChecks++; if (rspData !== 16'hBEEF) $display("[TB] FAIL b2bSecondRdata: got %h expected beef", rspData); else nPass++;
  endtask

  task automatic test_reset_mid();
    int waited, rspSeen;
    sel = 1;
    @(negedge clk);
    reqAddr = 32'h0020_000C; reqWe = 1'b1; reqBe = 2'b11; reqWdata = 16'h1234; reqValid = 1'b1;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    waited = 0;
    while (webLo !== 1'b0 && waited < 12) begin
      @(posedge clk);
      #1;
      waited++;
    end
    nChecks++; if (webLo !== 1'b0) $display("[TB] FAIL midReachData: WEb_lo=%b expected 0 within 12 edges", webLo); else nPass++;
    #2;
    rst = 1'b1;
    #1;
    nChecks++; if ({webLo, webHi, oeb} !== 3'b111) $display("[TB] FAIL midStrobesHigh: got %b expected 111", {webLo, webHi, oeb}); else nPass++;
    nChecks++; if (dir !== 1'b1)  $display("[TB] FAIL midDir: got %b expected 1", dir); else nPass++;
    rspSeen = 0;
    @(negedge clk);
    if (rspValid) rspSeen++;
    rst = 1'b0;
    #1;
    if (rspValid) rspSeen++;
    @(posedge clk);
    #1;
    nChecks++; if (ready !== 1'b1) $display("[TB] FAIL midReadyAfterRelease: got %b expected 1", ready); else nPass++;
    repeat (6) begin
      if (rspValid) rspSeen++;
      @(posedge clk);
      #1;
    end
    nChecks++; if (rspSeen !== 0) $display("[TB] FAIL midNoRsp: got %0d pulses expected 0", rspSeen); else nPass++;
  endtask

  initial begin
    sel = 0;
    test_reset();
    test_write();
    test_read();
    test_be_zero();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
